// File: rtl/cpu_io_port_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_io_port_pkg
//  Description : Shared word type, default sizing and width helper for the
//                CPU I/O port slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_io_port_pkg;

    localparam int unsigned c_WORD_W             = 8;
    localparam int unsigned c_DB_MAX_DEFAULT     = 1250000;
    localparam int unsigned c_FIFO_DEPTH_DEFAULT = 4;

    typedef logic [c_WORD_W-1:0] word_t;

    // Occupancy needs one extra bit so that "full" is representable.
    function automatic int unsigned f_count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : cpu_io_port_pkg
`default_nettype wire

// File: rtl/io_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : io_fifo
//  Description : Parameterised first-word-fall-through synchronous FIFO.
//                A push while full is only accepted when a pop frees a slot
//                in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_fifo
    import cpu_io_port_pkg::*;
#(
    parameter int unsigned DW    = c_WORD_W,
    parameter int unsigned DEPTH = c_FIFO_DEPTH_DEFAULT,
    parameter int unsigned CW    = f_count_width(c_FIFO_DEPTH_DEFAULT)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    localparam int unsigned c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_wr_en;
    logic w_rd_en;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_rd_en = i_pop && !w_empty;
    assign w_wr_en = i_push && (!w_full || w_rd_en);

    always_ff @(posedge Clock) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule : io_fifo
`default_nettype wire

// File: rtl/synchroniser.sv
`default_nettype none
// ============================================================================
//  Module      : synchroniser
//  Description : Two-flop synchroniser for one asynchronous input bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module synchroniser (
    input  logic Clock,
    input  logic Reset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule : synchroniser
`default_nettype wire

// File: rtl/cpu_io_port.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_io_port
//  Description : Board-side CPU data port: debounced Enter/switch latch toward
//                the CPU, de-duplicated capture of CPU output words into a
//                FWFT FIFO drained by the display logic.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_io_port
    import cpu_io_port_pkg::*;
#(
    parameter int unsigned DB_MAX     = c_DB_MAX_DEFAULT,
    parameter int unsigned FIFO_DEPTH = c_FIFO_DEPTH_DEFAULT,
    parameter int unsigned CW         = f_count_width(c_FIFO_DEPTH_DEFAULT)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [7:0]    Sw,
    input  logic          Enter,
    output logic [7:0]    Din,
    output logic          Sample,
    input  logic [7:0]    Dout,
    input  logic          Dval,
    output logic [7:0]    Odata,
    output logic          Ovalid,
    input  logic          Oready,
    output logic [CW-1:0] Count,
    output logic          Overflow
);

    localparam int unsigned c_DBW = (DB_MAX > 1) ? $clog2(DB_MAX) : 1;
    localparam logic [c_DBW-1:0] c_DB_LAST = c_DBW'(DB_MAX - 1);

    logic        w_enter_sync;
    word_t       w_sw_sync;
    logic [c_DBW-1:0] r_db_cnt;
    logic        r_level;
    word_t       r_din;

    word_t       r_last;
    logic        r_have_last;
    logic        r_overflow;
    logic        w_capture;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    word_t       w_head;
    logic [CW-1:0] w_count;

    synchroniser u_enter_sync (
        .Clock   (Clock),
        .Reset   (Reset),
        .i_async (Enter),
        .o_sync  (w_enter_sync)
    );

    for (genvar gi = 0; gi < c_WORD_W; gi++) begin : g_sw_sync
        synchroniser u_sw_sync (
            .Clock   (Clock),
            .Reset   (Reset),
            .i_async (Sw[gi]),
            .o_sync  (w_sw_sync[gi])
        );
    end

    // Switches are latched only on the rising debounced edge so Din is
    // stable for the whole time Sample is high.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_db_cnt <= '0;
            r_level  <= 1'b0;
            r_din    <= '0;
        end else if (w_enter_sync != r_level) begin
            if (r_db_cnt == c_DB_LAST) begin
                r_db_cnt <= '0;
                r_level  <= w_enter_sync;
                if (w_enter_sync) begin
                    r_din <= w_sw_sync;
                end
            end else begin
                r_db_cnt <= r_db_cnt + c_DBW'(1);
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

    assign Din    = r_din;
    assign Sample = r_level;

    assign w_capture = Dval && (!r_have_last || (Dout != r_last));
    assign w_pop     = !w_empty && Oready;

    // The last-captured word tracks even dropped captures so a held value
    // is never retried.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_last      <= '0;
            r_have_last <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_last      <= Dout;
                r_have_last <= 1'b1;
            end
            if (w_capture && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    io_fifo #(
        .DW    (c_WORD_W),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .Clock   (Clock),
        .Reset   (Reset),
        .i_push  (w_capture),
        .i_pop   (w_pop),
        .i_wdata (Dout),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign Odata    = w_head;
    assign Ovalid   = !w_empty;
    assign Count    = w_count;
    assign Overflow = r_overflow;

endmodule : cpu_io_port
`default_nettype wire

// File: tb/tb_cpu_io_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_io_port
//  Description : Directed self-checking bench for cpu_io_port
//                (DB_MAX=4, FIFO_DEPTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_io_port;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] Sw;
    logic       Enter;
    logic [7:0] Din;
    logic       Sample;
    logic [7:0] Dout;
    logic       Dval;
    logic [7:0] Odata;
    logic       Ovalid;
    logic       Oready;
    logic [2:0] Count;
    logic       Overflow;

    int n_vec = 0;
    int n_bad = 0;

    cpu_io_port #(
        .DB_MAX     (4),
        .FIFO_DEPTH (4),
        .CW         (3)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Sw       (Sw),
        .Enter    (Enter),
        .Din      (Din),
        .Sample   (Sample),
        .Dout     (Dout),
        .Dval     (Dval),
        .Odata    (Odata),
        .Ovalid   (Ovalid),
        .Oready   (Oready),
        .Count    (Count),
        .Overflow (Overflow)
    );

    always #5 Clock = ~Clock;

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Sw = 8'h00; Enter = 1'b0; Dout = 8'h00; Dval = 1'b0; Oready = 1'b0;
        tick(3);
        Reset = 1'b0;
        tick(1);
        n_vec++;
        if ({Din, Sample, Ovalid, Count, Overflow} !== 14'h0) begin
            n_bad++;
            $display("FAIL reset_state: got Din=%h Sample=%b Ovalid=%b Count=%0d Overflow=%b want all zero",
                     Din, Sample, Ovalid, Count, Overflow);
        end
    endtask

    task automatic test_debounce();
        Sw = 8'hA5;
        Enter = 1'b1; tick(1);
        Enter = 1'b0; tick(1);
        Enter = 1'b1; tick(1);
        Enter = 1'b0; tick(1);
        Enter = 1'b1;
        tick(5);
        n_vec++;
        if (Sample !== 1'b0) begin
            n_bad++;
            $display("FAIL debounce_early: Sample=%b after 5 edges, want 0", Sample);
        end
        tick(1);
        n_vec++;
        if (Sample !== 1'b1) begin
            n_bad++;
            $display("FAIL debounce_rise: Sample=%b after 6 edges, want 1", Sample);
        end
        n_vec++;
        if (Din !== 8'hA5) begin
            n_bad++;
            $display("FAIL din_latch: Din=%h want a5", Din);
        end
        Sw = 8'h5A;
        tick(6);
        n_vec++;
        if (Din !== 8'hA5 || Sample !== 1'b1) begin
            n_bad++;
            $display("FAIL din_hold: Din=%h Sample=%b want a5 1", Din, Sample);
        end
    endtask

    task automatic test_dedup();
        Dval = 1'b1; Dout = 8'h3C;
        tick(10);
        Dout = 8'h3D;
        tick(1);
        Dval = 1'b0;
        n_vec++;
        if (Count !== 3'd2) begin
            n_bad++;
            $display("FAIL dedup_count: Count=%0d want 2", Count);
        end
        Oready = 1'b1;
        n_vec++;
        if (Ovalid !== 1'b1 || Odata !== 8'h3C) begin
            n_bad++;
            $display("FAIL dedup_pop0: Ovalid=%b Odata=%h want 1 3c", Ovalid, Odata);
        end
        tick(1);
        n_vec++;
        if (Ovalid !== 1'b1 || Odata !== 8'h3D) begin
            n_bad++;
            $display("FAIL dedup_pop1: Ovalid=%b Odata=%h want 1 3d", Ovalid, Odata);
        end
        tick(1);
        Oready = 1'b0;
        n_vec++;
        if (Ovalid !== 1'b0 || Count !== 3'd0) begin
            n_bad++;
            $display("FAIL dedup_empty: Ovalid=%b Count=%0d want 0 0", Ovalid, Count);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_words [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        Oready = 1'b0; Dval = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            Dout = 8'(i);
            tick(1);
        end
        n_vec++;
        if (Count !== 3'd4 || Overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_full: Count=%0d Overflow=%b want 4 0", Count, Overflow);
        end
        Dout = 8'h05;
        tick(1);
        Dval = 1'b0;
        n_vec++;
        if (Count !== 3'd4 || Overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_drop: Count=%0d Overflow=%b want 4 1", Count, Overflow);
        end
        Oready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (Ovalid !== 1'b1 || Odata !== exp_words[i]) begin
                n_bad++;
                $display("FAIL ovf_drain%0d: Ovalid=%b Odata=%h want 1 %h", i, Ovalid, Odata, exp_words[i]);
            end
            tick(1);
        end
        Oready = 1'b0;
        n_vec++;
        if (Ovalid !== 1'b0 || Count !== 3'd0 || Overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_after: Ovalid=%b Count=%0d Overflow=%b want 0 0 1", Ovalid, Count, Overflow);
        end
    endtask

    task automatic test_reset_mid();
        Dval = 1'b1;
        for (int i = 6; i <= 8; i++) begin
            Dout = 8'(i);
            tick(1);
        end
        Dval = 1'b0;
        n_vec++;
        if (Count !== 3'd3 || Sample !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_pre: Count=%0d Sample=%b want 3 1", Count, Sample);
        end
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        n_vec++;
        if ({Din, Sample, Ovalid, Count, Overflow} !== 14'h0) begin
            n_bad++;
            $display("FAIL mid_reset: got Din=%h Sample=%b Ovalid=%b Count=%0d Overflow=%b want all zero",
                     Din, Sample, Ovalid, Count, Overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_words [4] = '{8'h0B, 8'h0C, 8'h0D, 8'h09};
        Oready = 1'b0; Dval = 1'b1;
        for (int i = 10; i <= 13; i++) begin
            Dout = 8'(i);
            tick(1);
        end
        n_vec++;
        if (Count !== 3'd4) begin
            n_bad++;
            $display("FAIL pp_full: Count=%0d want 4", Count);
        end
        Dout = 8'h09; Oready = 1'b1;
        tick(1);
        Dval = 1'b0; Oready = 1'b0;
        n_vec++;
        if (Count !== 3'd4 || Overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL pp_same: Count=%0d Overflow=%b want 4 0", Count, Overflow);
        end
        Oready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (Ovalid !== 1'b1 || Odata !== exp_words[i]) begin
                n_bad++;
                $display("FAIL pp_drain%0d: Ovalid=%b Odata=%h want 1 %h", i, Ovalid, Odata, exp_words[i]);
            end
            tick(1);
        end
        Oready = 1'b0;
        n_vec++;
        if (Ovalid !== 1'b0 || Count !== 3'd0) begin
            n_bad++;
            $display("FAIL pp_empty: Ovalid=%b Count=%0d want 0 0", Ovalid, Count);
        end
    endtask

    task automatic test_underflow();
        Dval = 1'b0; Oready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            n_vec++;
            if (Count !== 3'd0 || Ovalid !== 1'b0) begin
                n_bad++;
                $display("FAIL underflow%0d: Count=%0d Ovalid=%b want 0 0", i, Count, Ovalid);
            end
        end
        Oready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_dedup();
        test_overflow();
        test_reset_mid();
        test_full_push_pop();
        test_underflow();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_cpu_io_port
`default_nettype wire
